// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the integer register bank write side.
//   N_DEFAULT / BITS_DEFAULT : default register count and data width
//   reg_ptr_t                : register index at the default register count
//   wb_entry_t               : buffered writeback entry {ptr, data}
package regfile_pkg;

    localparam int unsigned N_DEFAULT    = 32;
    localparam int unsigned BITS_DEFAULT = 64;

    typedef logic [$clog2(N_DEFAULT)-1:0] reg_ptr_t;

    typedef struct packed {
        reg_ptr_t                ptr;
        logic [BITS_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries, head visible combinationally.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry
//   full/empty : occupancy flags
module wb_fifo
    import regfile_pkg::*;
#(
    parameter type         T     = wb_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: owns the register bank write port. Merges single-cycle
// ALU results (absolute priority) with buffered long-latency results, and
// keeps a busy scoreboard of outstanding long-latency destinations.
// Ports:
//   clk, rst                    : clock; asynchronous active-low reset
//   issue_valid, issue_rd       : long op issued, marks busy[issue_rd]
//   alu_valid, alu_rd, alu_data : ALU result, always accepted
//   lu_valid, lu_rd, lu_data    : long-unit result, handshake with lu_ready
//   lu_ready                    : buffer not full (combinational)
//   ptr_wr, data_wr, wr_en      : registered register bank write port
//   busy                        : registered scoreboard, bit i = pending
// Optional feature macro: WB_BYPASS_EN -- a long result arriving with the
// buffer empty and no ALU traffic is written directly, one cycle earlier.
module reg_writeback_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned N      = N_DEFAULT,
    parameter int unsigned Bits   = BITS_DEFAULT,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [$clog2(N)-1:0] issue_rd,
    input  logic                 alu_valid,
    input  logic [$clog2(N)-1:0] alu_rd,
    input  logic [Bits-1:0]      alu_data,
    input  logic                 lu_valid,
    input  logic [$clog2(N)-1:0] lu_rd,
    input  logic [Bits-1:0]      lu_data,
    output logic                 lu_ready,
    output logic [$clog2(N)-1:0] ptr_wr,
    output logic [Bits-1:0]      data_wr,
    output logic                 wr_en,
    output logic [N-1:0]         busy
);

    localparam int unsigned PW = $clog2(N);

    typedef struct packed {
        logic [PW-1:0]   ptr;
        logic [Bits-1:0] data;
    } entry_t;

    entry_t          lu_entry;
    entry_t          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            bypass;

    logic            lu_wb;
    logic [PW-1:0]   lu_wb_rd;

    logic            wr_en_d,  wr_en_q;
    logic [PW-1:0]   ptr_d,    ptr_q;
    logic [Bits-1:0] data_d,   data_q;
    logic [N-1:0]    busy_d,   busy_q;

    assign lu_entry = '{ptr: lu_rd, data: lu_data};
    assign lu_ready = !fifo_full;

`ifdef WB_BYPASS_EN
    // Empty buffer implies lu_ready, so this is an accepted handshake.
    assign bypass = lu_valid && fifo_empty && !alu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = lu_valid && lu_ready && !bypass;
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_fifo #(
        .T     (entry_t),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (lu_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Write-port arbitration. A winner targeting register 0 is still consumed
    // but produces no write; ptr/data hold their last written values.
    always_comb begin
        wr_en_d  = 1'b0;
        ptr_d    = ptr_q;
        data_d   = data_q;
        lu_wb    = 1'b0;
        lu_wb_rd = '0;
        if (alu_valid) begin
            if (alu_rd != '0) begin
                wr_en_d = 1'b1;
                ptr_d   = alu_rd;
                data_d  = alu_data;
            end
        end else if (bypass) begin
            lu_wb    = 1'b1;
            lu_wb_rd = lu_rd;
            if (lu_rd != '0) begin
                wr_en_d = 1'b1;
                ptr_d   = lu_rd;
                data_d  = lu_data;
            end
        end else if (fifo_pop) begin
            lu_wb    = 1'b1;
            lu_wb_rd = head.ptr;
            if (head.ptr != '0) begin
                wr_en_d = 1'b1;
                ptr_d   = head.ptr;
                data_d  = head.data;
            end
        end
    end

    // Set is applied after clear so a newly issued op on the retiring
    // register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (lu_wb) begin
            busy_d[lu_wb_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q <= 1'b0;
            ptr_q   <= '0;
            data_q  <= '0;
            busy_q  <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign ptr_wr  = ptr_q;
    assign data_wr = data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [63:0] lu_data = '0;
    logic        lu_ready;
    logic [4:0]  ptr_wr;
    logic [63:0] data_wr;
    logic        wr_en;
    logic [31:0] busy;

    typedef struct {
        logic [4:0]  ptr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t alu_q[$];
    exp_t lu_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    reg_writeback_ctrl #(
        .N      (32),
        .Bits   (64),
        .QDEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .ptr_wr      (ptr_wr),
        .data_wr     (data_wr),
        .wr_en       (wr_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ALU result written exactly one cycle after it is driven.
    task automatic drive_alu(input logic [4:0] rd, input logic [63:0] d);
        exp_t e;
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        if (rd != 5'd0) begin
            e.ptr  = rd;
            e.data = d;
            e.cyc  = cyc + 1;
            alu_q.push_back(e);
        end
    endtask

    task automatic expect_lu(input logic [4:0] rd, input logic [63:0] d);
        exp_t e;
        e.ptr  = rd;
        e.data = d;
        e.cyc  = 0;
        lu_q.push_back(e);
    endtask

    // Scoreboard: ALU writes are due on a known cycle; any other write must
    // be the oldest accepted long result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b1) begin
            if (alu_q.size() > 0 && alu_q[0].cyc <= cyc) begin
                e = alu_q.pop_front();
                chk("alu_wr_en", wr_en, 1'b1);
                chk("alu_ptr", ptr_wr, e.ptr);
                chk("alu_data", data_wr, e.data);
            end else if (wr_en === 1'b1) begin
                if (lu_q.size() > 0) begin
                    e = lu_q.pop_front();
                    chk("lu_ptr", ptr_wr, e.ptr);
                    chk("lu_data", data_wr, e.data);
                end else begin
                    chk("unexpected_wr", wr_en, 1'b0);
                end
            end
        end
    end

    initial begin
        int k;
        int n;

        // Reset values
        repeat (2) step();
        @(negedge clk);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_ptr", ptr_wr, 5'd0);
        chk("rst_data", data_wr, 64'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_lu_ready", lu_ready, 1'b1);
        step();
        rst = 1'b1;

        // ALU path
        step();
        drive_alu(5'd5, 64'hDEAD_BEEF);
        @(negedge clk);
        chk("alu_pre_wr_en", wr_en, 1'b0);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_t1_wr_en", wr_en, 1'b1);
        chk("alu_t1_ptr", ptr_wr, 5'd5);
        chk("alu_t1_data", data_wr, 64'hDEAD_BEEF);
        step();
        @(negedge clk);
        chk("alu_t2_wr_en", wr_en, 1'b0);

        // Long path with scoreboard
        step();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("busy7_set", busy[7], 1'b1);
        step();
        lu_valid = 1'b1;
        lu_rd    = 5'd7;
        lu_data  = 64'h1234;
        @(negedge clk);
        chk("lu_ready_t", lu_ready, 1'b1);
        expect_lu(5'd7, 64'h1234);
        step();
        lu_valid = 1'b0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("lu_t1_wr_en", wr_en, 1'b1);
        chk("lu_t1_busy7", busy[7], 1'b0);
`else
        chk("lu_t1_wr_en", wr_en, 1'b0);
        chk("lu_t1_busy7", busy[7], 1'b1);
`endif
        step();
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("lu_t2_wr_en", wr_en, 1'b0);
`else
        chk("lu_t2_wr_en", wr_en, 1'b1);
        chk("lu_t2_ptr", ptr_wr, 5'd7);
`endif
        chk("lu_t2_busy7", busy[7], 1'b0);

        // Contention: ALU busy for 6 cycles, 5 long results offered
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c < 6) drive_alu(5'(10 + c), 64'hA0 + 64'(c));
            else alu_valid = 1'b0;
            if (k < 5) begin
                lu_valid = 1'b1;
                lu_rd    = 5'(16 + k);
                lu_data  = 64'h5000 + 64'(k);
            end else begin
                lu_valid = 1'b0;
            end
            @(negedge clk);
            if (k == 4 && c < 6) chk("lu_ready_full", lu_ready, 1'b0);
            if (lu_valid && lu_ready) begin
                expect_lu(lu_rd, lu_data);
                k++;
            end
        end
        lu_valid = 1'b0;
        chk("lu_accepted", 64'(k), 64'd5);
        n = 0;
        while ((lu_q.size() + alu_q.size()) != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_done", 64'(lu_q.size() + alu_q.size()), 64'd0);

        // Register 0 is never written
        step();
        drive_alu(5'd0, 64'h99);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("rd0_wr_en", wr_en, 1'b0);

        // Same-edge set and clear of register 3
        step();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        step();
        issue_valid = 1'b0;
        step();
        lu_valid = 1'b1;
        lu_rd    = 5'd3;
        lu_data  = 64'h33;
        expect_lu(5'd3, 64'h33);
`ifdef WB_BYPASS_EN
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        step();
        lu_valid    = 1'b0;
        issue_valid = 1'b0;
`else
        step();
        lu_valid    = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        step();
        issue_valid = 1'b0;
`endif
        @(negedge clk);
        chk("same_edge_wr_en", wr_en, 1'b1);
        chk("busy3_set_wins", busy[3], 1'b1);
        step();
        lu_valid = 1'b1;
        lu_rd    = 5'd3;
        lu_data  = 64'h34;
        expect_lu(5'd3, 64'h34);
        step();
        lu_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("busy_all_clear", busy, 32'd0);

        // Reset mid-stream with buffered entries and busy bits
        for (int i = 4; i < 8; i++) begin
            step();
            issue_valid = 1'b1;
            issue_rd    = 5'(i);
        end
        step();
        issue_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            drive_alu(5'd9, 64'hC0 + 64'(j));
            lu_valid = 1'b1;
            lu_rd    = 5'(j + 1);
            lu_data  = 64'hE0 + 64'(j);
            expect_lu(5'(j + 1), 64'hE0 + 64'(j));
        end
        step();
        drive_alu(5'd9, 64'hC3);
        lu_valid = 1'b0;
        @(negedge clk);
        chk("busy_pre_reset", busy, 32'h0000_00F0);
        #2;
        rst       = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 1'b0);
        chk("mid_rst_ptr", ptr_wr, 5'd0);
        chk("mid_rst_data", data_wr, 64'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_lu_ready", lu_ready, 1'b1);
        alu_q.delete();
        lu_q.delete();
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("post_rst_wr_en", wr_en, 1'b0);
        end
        chk("post_rst_lu_ready", lu_ready, 1'b1);
        chk("post_rst_busy", busy, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_ctrl.md
# reg_writeback_ctrl

Write-side controller for the integer register bank: it owns the bank's single write port and merges two result streams onto it. One stream is single-cycle ALU results; the other is valid/ready long-latency unit results (load/mul/div). It keeps a per-register busy scoreboard for outstanding long-latency destinations, which issue logic uses for stalls. It sits between the execute/memory units and the register bank's `ptr_wr` / `data_wr` / `wr_en` inputs.

## Interface
- `N`, default 32: number of architectural registers, power of two.
- `Bits`, default 64: data width.
- `QDEPTH`, default 4: long-result buffer depth, power of two, ≥2.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `issue_valid` input 1: a long-latency op is issued this cycle.
- `issue_rd` input $clog2(N): destination of the issued long op.
- `alu_valid` input 1: ALU result present; always accepted.
- `alu_rd` input $clog2(N): ALU destination.
- `alu_data` input Bits: ALU result.
- `lu_valid` input 1: long-unit result present.
- `lu_rd` input $clog2(N): long-unit destination.
- `lu_data` input Bits: long-unit result.
- `lu_ready` output 1: buffer can accept; combinational, equals not-full.
- `ptr_wr` output $clog2(N): register bank write pointer, registered.
- `data_wr` output Bits: register bank write data, registered.
- `wr_en` output 1: register bank write enable, registered.
- `busy` output N: scoreboard; bit i = long result pending for register i, registered.

## Operation
- Scoreboard set: `issue_valid` with `issue_rd`≠0 sets `busy[issue_rd]`. Register 0 is never marked.
- Long-unit accept: a handshake (`lu_valid && lu_ready`) pushes {rd, data} into the FIFO.
- Write-port arbitration each cycle:
  - ALU has absolute priority.
  - If `alu_valid` is 0 and the FIFO is non-empty, the FIFO head is popped and written.
- Destination 0 is never written. The winning source is consumed, but `wr_en` stays 0 for that slot.
- Scoreboard clear: a long-unit writeback clears `busy[rd]` on the same edge that loads `wr_en`. ALU writebacks never touch `busy`.
- Set and clear of the same register on the same edge: set wins, because a newer op is pending.
- An ALU write to a busy register is legal, and the register stays busy. Ordering is the issue logic's responsibility.
- FIFO full: `lu_ready`=0, and the long unit holds its data. A pop and a push in the same full cycle are not allowed, because ready is pure not-full.
- Starvation is permitted. Continuous `alu_valid` stalls FIFO drain indefinitely.

## Timing
- Reset values: `wr_en`=0, `ptr_wr`=0, `data_wr`=0, `busy`=0, FIFO empty. `lu_ready`=1 while in reset and after it.
- Reset asserted mid-operation clears all buffered results and the scoreboard immediately.
- ALU result presented in cycle t: `wr_en`=1 with that data in cycle t+1.
- Long result accepted in cycle t, with no ALU traffic: enters the FIFO at edge t, is popped in t+1, and `wr_en` is high in t+2. The matching `busy` bit reads 0 from t+2.
- Each extra cycle of ALU occupancy adds one cycle of long-result latency.
- FIFO order is strict: long results are written back in acceptance order.
- `wr_en` is high for exactly one cycle per write. Back-to-back writes on consecutive cycles are supported.

## Configuration
- `WB_BYPASS_EN` defined:
  - A long result accepted while the FIFO is empty and `alu_valid`=0 skips the FIFO.
  - It is written at t+1, and `busy` clears at t+1.
  - In all other cases it behaves exactly as without the macro.
- `WB_BYPASS_EN` undefined: all long results pass through the FIFO, with a minimum latency of 2.

## Structure
- Package `regfile_pkg`:
  - default `N` and `Bits`
  - `reg_ptr_t` typedef
  - `wb_entry_t` struct {ptr, data}
- Sub-module `wb_fifo`: synchronous FIFO of `wb_entry_t`, with push/pop/full/empty.
- Arbitration, scoreboard, and output registers live in the top module.

## Test plan
- Reset: drive `rst`=0 mid-stream with 3 entries buffered and `busy`=0x0000_00F0. Required: all outputs at reset values immediately; FIFO empty after release; `lu_ready`=1.
- ALU path: `alu_valid`, rd=5, data=0xDEAD_BEEF at cycle t. Required: `wr_en`=1, `ptr_wr`=5, `data_wr`=0xDEAD_BEEF at t+1, then `wr_en`=0.
- Long path with scoreboard: issue rd=7; at t accept lu rd=7, data=0x1234. Required: `busy[7]`=1 until write; write seen at t+2 (t+1 with `WB_BYPASS_EN`); `busy[7]`=0 after.
- Contention and full:
  - Hold `alu_valid` for 6 cycles while pushing 5 long results.
  - Required: `lu_ready`=0 after 4 accepted.
  - Required: ALU writes occur every cycle.
  - Required: then 4 long writes drain in order, then the fifth.
- Register 0 and same-edge set/clear:
  - ALU write to rd=0: required `wr_en` stays 0.
  - Issue rd=3 on the same cycle a long write to rd=3 retires: required `busy[3]`=1 afterwards.
